// File: rtl/des_sbox_unit.sv
// des_sbox_unit: sequential DES S-box stage (S1..S8), LANES lookups per cycle.
// Consumes a 48-bit keyed half-block and produces the 32-bit S-box output.
// Optional macro DES_SBOX_PERM_EN: drive out_data through the DES P permutation.
//
// Handshake: a transfer happens on a rising edge where valid and ready are both
// high. in_ready depends only on state and out_ready (never on in_valid);
// out_valid depends only on state. Once out_valid is high, out_data holds
// stable until the consumer takes it.
module des_sbox_unit #(
  parameter int LANES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [47:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        busy
);

  localparam int N = 8 / LANES;
  localparam logic [2:0] G_LAST = 3'(N - 1);

  generate
    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8)) begin : g_bad_lanes
      $error("des_sbox_unit: LANES must be 1, 2, 4 or 8");
    end
  endgenerate

  // S1..S8 packed back to back, S1 in the top 256 bits. Each box holds 64
  // nibbles in FIPS row-major order (row 0 col 0 first, at the MSB end).
  localparam logic [2047:0] SBOX_ROM = {
    256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
    256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
    256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
    256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
    256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
    256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
    256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
    256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B
  };

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic [2:0]  g;
  logic [47:0] cap;
  logic [31:0] acc;
  logic        load;
  logic [3:0]  lane_nib [LANES];

  // Row is {b5,b0} and column is b4..b1, so the row-major entry number is
  // simply the chunk bits reordered as {b5,b0,b4,b3,b2,b1}.
  function automatic logic [3:0] sbox_lookup(input int box, input logic [5:0] chunk);
    int base;
    base = 2047 - box * 256 - 4 * int'({chunk[5], chunk[0], chunk[4:1]});
    return SBOX_ROM[base -: 4];
  endfunction

  // Lookups for the group of boxes selected by g, read from the captured block.
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      lane_nib[l] = sbox_lookup(int'(g) * LANES + l,
                                cap[47 - 6 * (int'(g) * LANES + l) -: 6]);
    end
  end

  // Next-state and handshake decode; load marks an accepting edge.
  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    load      = 1'b0;
    case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          load     = 1'b1;
          state_nx = S_RUN;
        end
      end
      S_RUN: begin
        if (g == G_LAST) state_nx = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          in_ready = 1'b1;
          if (in_valid) begin
            load     = 1'b1;
            state_nx = S_RUN;
          end else begin
            state_nx = S_IDLE;
          end
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // State, capture register, group counter and accumulator.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      g     <= '0;
      cap   <= '0;
      acc   <= '0;
    end else begin
      state <= state_nx;
      if (load) begin
        cap <= in_data;
        g   <= '0;
      end else if (state == S_RUN) begin
        for (int l = 0; l < LANES; l++) begin
          acc[31 - 4 * (int'(g) * LANES + l) -: 4] <= lane_nib[l];
        end
        if (g != G_LAST) g <= g + 3'd1;
      end
    end
  end

  assign busy = (state == S_RUN) || (state == S_DONE);

`ifdef DES_SBOX_PERM_EN
  // DES P table, 1-based with bit 1 as the MSB.
  localparam int P_TAB [32] = '{16, 7, 20, 21, 29, 12, 28, 17, 1, 15, 23, 26, 5, 18, 31, 10,
                                2, 8, 24, 14, 32, 27, 3, 9, 19, 13, 30, 6, 22, 11, 4, 25};

  // Pure wiring from the accumulator through P; no added latency.
  always_comb begin
    out_data = '0;
    for (int i = 0; i < 32; i++) begin
      out_data[31 - i] = acc[32 - P_TAB[i]];
    end
  end
`else
  assign out_data = acc;
`endif

endmodule

// File: tb/tb_des_sbox_unit.sv
// tb_des_sbox_unit: directed bench for des_sbox_unit; four instances
// (LANES = 1, 2, 4, 8) share the inputs. Honours DES_SBOX_PERM_EN.
module tb_des_sbox_unit;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        out_ready;
  logic [47:0] in_data;
  logic [3:0]  ir;
  logic [3:0]  ov;
  logic [3:0]  bz;
  logic [31:0] od [4];

  int vectors;
  int miscompares;
  int n_of [4] = '{8, 4, 2, 1};
  int lanes_of [4] = '{1, 2, 4, 8};
  logic [31:0] exp_q [$];

  // FIPS 46-3 S-boxes, [box][row][column], decimal as printed in the standard.
  int s_tab [8][4][16] = '{
    '{'{14, 4, 13, 1, 2, 15, 11, 8, 3, 10, 6, 12, 5, 9, 0, 7},
      '{0, 15, 7, 4, 14, 2, 13, 1, 10, 6, 12, 11, 9, 5, 3, 8},
      '{4, 1, 14, 8, 13, 6, 2, 11, 15, 12, 9, 7, 3, 10, 5, 0},
      '{15, 12, 8, 2, 4, 9, 1, 7, 5, 11, 3, 14, 10, 0, 6, 13}},
    '{'{15, 1, 8, 14, 6, 11, 3, 4, 9, 7, 2, 13, 12, 0, 5, 10},
      '{3, 13, 4, 7, 15, 2, 8, 14, 12, 0, 1, 10, 6, 9, 11, 5},
      '{0, 14, 7, 11, 10, 4, 13, 1, 5, 8, 12, 6, 9, 3, 2, 15},
      '{13, 8, 10, 1, 3, 15, 4, 2, 11, 6, 7, 12, 0, 5, 14, 9}},
    '{'{10, 0, 9, 14, 6, 3, 15, 5, 1, 13, 12, 7, 11, 4, 2, 8},
      '{13, 7, 0, 9, 3, 4, 6, 10, 2, 8, 5, 14, 12, 11, 15, 1},
      '{13, 6, 4, 9, 8, 15, 3, 0, 11, 1, 2, 12, 5, 10, 14, 7},
      '{1, 10, 13, 0, 6, 9, 8, 7, 4, 15, 14, 3, 11, 5, 2, 12}},
    '{'{7, 13, 14, 3, 0, 6, 9, 10, 1, 2, 8, 5, 11, 12, 4, 15},
      '{13, 8, 11, 5, 6, 15, 0, 3, 4, 7, 2, 12, 1, 10, 14, 9},
      '{10, 6, 9, 0, 12, 11, 7, 13, 15, 1, 3, 14, 5, 2, 8, 4},
      '{3, 15, 0, 6, 10, 1, 13, 8, 9, 4, 5, 11, 12, 7, 2, 14}},
    '{'{2, 12, 4, 1, 7, 10, 11, 6, 8, 5, 3, 15, 13, 0, 14, 9},
      '{14, 11, 2, 12, 4, 7, 13, 1, 5, 0, 15, 10, 3, 9, 8, 6},
      '{4, 2, 1, 11, 10, 13, 7, 8, 15, 9, 12, 5, 6, 3, 0, 14},
      '{11, 8, 12, 7, 1, 14, 2, 13, 6, 15, 0, 9, 10, 4, 5, 3}},
    '{'{12, 1, 10, 15, 9, 2, 6, 8, 0, 13, 3, 4, 14, 7, 5, 11},
      '{10, 15, 4, 2, 7, 12, 9, 5, 6, 1, 13, 14, 0, 11, 3, 8},
      '{9, 14, 15, 5, 2, 8, 12, 3, 7, 0, 4, 10, 1, 13, 11, 6},
      '{4, 3, 2, 12, 9, 5, 15, 10, 11, 14, 1, 7, 6, 0, 8, 13}},
    '{'{4, 11, 2, 14, 15, 0, 8, 13, 3, 12, 9, 7, 5, 10, 6, 1},
      '{13, 0, 11, 7, 4, 9, 1, 10, 14, 3, 5, 12, 2, 15, 8, 6},
      '{1, 4, 11, 13, 12, 3, 7, 14, 10, 15, 6, 8, 0, 5, 9, 2},
      '{6, 11, 13, 8, 1, 4, 10, 7, 9, 5, 0, 15, 14, 2, 3, 12}},
    '{'{13, 2, 8, 4, 6, 15, 11, 1, 10, 9, 3, 14, 5, 0, 12, 7},
      '{1, 15, 13, 8, 10, 3, 7, 4, 12, 5, 6, 11, 0, 14, 9, 2},
      '{7, 11, 4, 1, 9, 12, 14, 2, 0, 6, 10, 13, 15, 3, 5, 8},
      '{2, 1, 14, 7, 4, 10, 8, 13, 15, 12, 9, 0, 3, 5, 6, 11}}
  };

  int p_tab [32] = '{16, 7, 20, 21, 29, 12, 28, 17, 1, 15, 23, 26, 5, 18, 31, 10,
                     2, 8, 24, 14, 32, 27, 3, 9, 19, 13, 30, 6, 22, 11, 4, 25};

  des_sbox_unit #(.LANES(1)) u_l1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[0]), .in_data(in_data),
    .out_valid(ov[0]), .out_ready(out_ready), .out_data(od[0]), .busy(bz[0]));
  des_sbox_unit #(.LANES(2)) u_l2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[1]), .in_data(in_data),
    .out_valid(ov[1]), .out_ready(out_ready), .out_data(od[1]), .busy(bz[1]));
  des_sbox_unit #(.LANES(4)) u_l4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[2]), .in_data(in_data),
    .out_valid(ov[2]), .out_ready(out_ready), .out_data(od[2]), .busy(bz[2]));
  des_sbox_unit #(.LANES(8)) u_l8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[3]), .in_data(in_data),
    .out_valid(ov[3]), .out_ready(out_ready), .out_data(od[3]), .busy(bz[3]));

  // Clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ref_raw(input logic [47:0] d);
    logic [31:0] r;
    logic [5:0]  c;
    r = '0;
    for (int b = 0; b < 8; b++) begin
      c = d[47 - 6 * b -: 6];
      r[31 - 4 * b -: 4] = 4'(s_tab[b][{c[5], c[0]}][c[4:1]]);
    end
    return r;
  endfunction

  function automatic logic [31:0] exp_out(input logic [31:0] raw);
`ifdef DES_SBOX_PERM_EN
    logic [31:0] y;
    y = '0;
    for (int i = 0; i < 32; i++) y[31 - i] = raw[32 - p_tab[i]];
    return y;
`else
    return raw;
`endif
  endfunction

  task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One block into all four instances; checks exact latency and data per instance.
  task automatic run_block(input logic [47:0] d, input logic [31:0] raw_exp);
    logic [31:0] e;
    e = exp_out(raw_exp);
    in_data   = d;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) chk($sformatf("in_ready_pre L%0d", lanes_of[i]), 48'(ir[i]), 48'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = {16'($urandom()), $urandom()};
    for (int step = 1; step <= 9; step++) begin
      @(posedge clk); #1;
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("out_valid L%0d step %0d d=%h", lanes_of[i], step, d),
            48'(ov[i]), 48'(step == n_of[i]));
        if (step == n_of[i])
          chk($sformatf("out_data L%0d d=%h", lanes_of[i], d), 48'(od[i]), 48'(e));
      end
    end
  endtask

  initial begin
    logic [47:0] d;
    logic [31:0] ea;
    logic [31:0] eb;
    vectors     = 0;
    miscompares = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_data   = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;

    // Reset state.
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rst in_ready L%0d", lanes_of[i]), 48'(ir[i]), 48'd1);
      chk($sformatf("rst out_valid L%0d", lanes_of[i]), 48'(ov[i]), 48'd0);
      chk($sformatf("rst out_data L%0d", lanes_of[i]), 48'(od[i]), 48'd0);
      chk($sformatf("rst busy L%0d", lanes_of[i]), 48'(bz[i]), 48'd0);
    end

    // Hand-computed corner blocks.
    run_block(48'h0, 32'hEFA72C4D);
    run_block(48'hFFFF_FFFF_FFFF, 32'hD9CE3DCB);
    run_block(48'd0 << 6, {24'hEFA72C, 4'd4, 4'hD});
    run_block(48'd1 << 6, {24'hEFA72C, 4'd13, 4'hD});
    run_block(48'd2 << 6, {24'hEFA72C, 4'd11, 4'hD});
    run_block(48'd63 << 6, {24'hEFA72C, 4'd12, 4'hD});

    // Every S-box entry, one box at a time, other chunks zero.
    for (int b = 0; b < 8; b++) begin
      for (int v = 0; v < 64; v++) begin
        d = 48'(v) << (6 * (7 - b));
        run_block(d, ref_raw(d));
      end
    end

    // Backpressure in DONE (LANES=2), then handoff plus new accept on one edge.
    ea = exp_out(ref_raw(48'h0123_4567_89AB));
    eb = exp_out(ref_raw(48'hFEDC_BA98_7654));
    in_data   = 48'h0123_4567_89AB;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    @(posedge clk); #1;
    in_data = 48'h5A5A_5A5A_5A5A;
    for (int step = 1; step <= 4; step++) begin
      @(posedge clk); #1;
      chk($sformatf("bp out_valid step %0d", step), 48'(ov[1]), 48'(step == 4));
    end
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      chk("bp hold out_valid", 48'(ov[1]), 48'd1);
      chk("bp hold out_data", 48'(od[1]), 48'(ea));
      chk("bp hold in_ready", 48'(ir[1]), 48'd0);
    end
    in_data   = 48'hFEDC_BA98_7654;
    out_ready = 1'b1;
    #1;
    chk("bp release in_ready", 48'(ir[1]), 48'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp reaccept out_valid", 48'(ov[1]), 48'd0);
    chk("bp reaccept busy", 48'(bz[1]), 48'd1);
    for (int step = 1; step <= 4; step++) begin
      @(posedge clk); #1;
      chk($sformatf("bp2 out_valid step %0d", step), 48'(ov[1]), 48'(step == 4));
    end
    chk("bp2 out_data", 48'(od[1]), 48'(eb));
    @(posedge clk); #1;
    chk("bp2 back to idle valid", 48'(ov[1]), 48'd0);
    chk("bp2 back to idle busy", 48'(bz[1]), 48'd0);

    // Reset in RUN with g=1 (LANES=2): block dropped, nothing stale appears.
    in_data  = 48'h1357_9BDF_2468;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("mid busy after accept", 48'(bz[1]), 48'd1);
    @(posedge clk); #1;
    chk("mid busy g1", 48'(bz[1]), 48'd1);
    chk("mid out_valid g1", 48'(ov[1]), 48'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid rst out_valid", 48'(ov[1]), 48'd0);
    chk("mid rst out_data", 48'(od[1]), 48'd0);
    chk("mid rst busy", 48'(bz[1]), 48'd0);
    chk("mid rst in_ready", 48'(ir[1]), 48'd1);
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      chk("mid post out_valid", 48'(ov[1]), 48'd0);
      chk("mid post out_data", 48'(od[1]), 48'd0);
    end

    // Random back-to-back traffic with random out_ready (LANES=2).
    for (int cyc = 0; cyc < 420; cyc++) begin
      if (cyc < 400) begin
        out_ready = ($urandom_range(0, 3) != 0);
        in_valid  = 1'($urandom_range(0, 1));
        d = {16'($urandom()), $urandom()};
        in_data = d;
      end else begin
        out_ready = 1'b1;
        in_valid  = 1'b0;
      end
      #1;
      if (in_valid && ir[1]) exp_q.push_back(exp_out(ref_raw(in_data)));
      if (ov[1] && out_ready) begin
        chk("rand output expected", 48'(exp_q.size() != 0), 48'd1);
        if (exp_q.size() != 0) chk("rand out_data", 48'(od[1]), 48'(exp_q.pop_front()));
      end
      @(posedge clk); #1;
    end
    chk("rand all delivered", 48'(exp_q.size()), 48'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/des_sbox_unit.md
Name: des_sbox_unit

Overview:
Parametrised, sequential DES substitution unit that replaces the single-box combinational lookups. It consumes one 48-bit expanded-and-keyed half-block and produces the 32-bit concatenated output of S-boxes S1..S8. It time-multiplexes LANES S-box lookups per cycle and uses valid/ready handshakes on both sides. It sits between the key-XOR stage and the round-function XOR in the DES datapath.

Parameters:
LANES, 2, S-boxes evaluated per cycle; legal values 1, 2, 4, 8; any other value is an elaboration error.
N (derived, localparam), 8/LANES, RUN cycles per block.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
in_valid  input  1  in_data valid
in_ready  output  1  unit can accept in_data this cycle
in_data  input  48  S-box input; bits [47:42] feed S1 … [5:0] feed S8
out_valid  output  1  out_data valid
out_ready  input  1  consumer accepts out_data
out_data  output  32  S1 result in [31:28] … S8 result in [3:0]
busy  output  1  high in RUN or DONE

Behaviour:
- Lookup: each S-box is indexed by its raw 6-bit chunk b5..b0; row = {b5,b0}, column = b4..b1; contents are the FIPS 46-3 S1..S8 tables. Example: S7 at index 0 = 4, index 1 = 13, index 63 = 12.
- State machine:
  - IDLE: in_ready = 1. On in_valid & in_ready, capture in_data into an internal 48-bit register, clear group counter g to 0, and go to RUN.
  - RUN: each cycle, evaluate S-boxes g*LANES+1 .. (g+1)*LANES from the captured register and write their nibbles into the 32-bit accumulator. Increment g. When g == N-1, go to DONE at that edge.
  - DONE: out_valid = 1 and out_data = accumulator. The unit holds state and data stable while out_ready = 0.
  - DONE with out_ready = 1: complete the handoff. If in_valid is also 1, capture the new block and go directly to RUN. Otherwise go to IDLE.
- in_ready = (state==IDLE) | (state==DONE & out_ready). The output is combinational from state and out_ready only; it does not depend on in_valid.
- Latency: out_valid asserts exactly N clock edges after the accepting edge. Sustained throughput is one block per N+1 cycles.
- in_data is sampled only on the accepting edge and may change freely afterwards.
- out_data is registered. It is don't-care outside DONE, but the accumulator is not modified in DONE.
- Reset values: state IDLE, in_ready 1 (after reset is released), out_valid 0, out_data 0, busy 0, g 0, accumulator 0, capture register 0.
- rst dominates every other input. Reset asserted in RUN or DONE drops the in-flight block with no output produced. The first cycle after reset is IDLE.
- LANES = 8: N = 1, so the unit runs one RUN cycle and then DONE.

Optional Feature:
DES_SBOX_PERM_EN
- When defined: out_data is the DES P permutation of the accumulator. Output bit i (1-based, MSB = 1) takes accumulator bit P[i], where P = 16 7 20 21 29 12 28 17 1 15 23 26 5 18 31 10 2 8 24 14 32 27 3 9 19 13 30 6 22 11 4 25. The permutation is pure wiring and latency is unchanged.
- When undefined: out_data is the raw S1..S8 concatenation.

Test Plan:
- in_data = 48'h0, LANES=2, out_ready=1 -> out_valid rises 4 edges after accept; out_data = 32'hEFA72C4D. With PERM_EN, out_data = P(32'hEFA72C4D).
- in_data = 48'hFFFFFFFFFFFF, LANES=1 -> out_valid 8 edges after accept; out_data = 32'hD9CE3DCB.
- Sweep each S-box separately: drive chunk k = 0..63 with the other chunks at 0; run for LANES = 1, 2, 4, 8 -> nibble matches the FIPS table. Includes S7: 0->4, 1->13, 2->11, 63->12.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> out_valid stays 1, out_data stable, in_ready 0. Then out_ready=1 with in_valid=1 -> handoff and new accept on the same edge, next out_valid N edges later.
- Assert rst for 1 cycle mid-RUN (g=1, LANES=2) -> next cycle IDLE, out_valid 0, out_data 0, busy 0. No stale output ever appears.
- Random back-to-back blocks with random out_ready -> every accepted block is delivered once and in order, matching the reference-model result.
